// File: rtl/macros.sv
// Shared fixed-point constants and conversion helpers for the FM receive chain.
// Samples and gains use signed Q.BITS; PCM is 16-bit signed.
package macros;

  localparam int BITS    = 10;
  localparam int PCM_MAX = 32767;
  localparam int PCM_MIN = -32768;

  function automatic logic signed [63:0] DEQUANTIZE(input logic signed [63:0] v);
    return v >>> BITS;
  endfunction

  function automatic logic pcm_clipped(input logic signed [63:0] v);
    return (v > longint'(PCM_MAX)) || (v < longint'(PCM_MIN));
  endfunction

  function automatic logic [15:0] SATURATE_PCM(input logic signed [63:0] v);
    logic [15:0] r;
    if (v > longint'(PCM_MAX))
      r = 16'h7fff;
    else if (v < longint'(PCM_MIN))
      r = 16'h8000;
    else
      r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/pcm_hold_fifo.sv
// In-order holding buffer for finished PCM words; head word is shown combinationally.
// Simultaneous write and read is allowed at any occupancy, including full.
module pcm_hold_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_dequant_out.sv
// Output stage: pops Q.BITS samples, applies Q.BITS volume, floors to integer,
// saturates to signed PCM and pushes into the audio output FIFO.
module audio_dequant_out
  import macros::SATURATE_PCM, macros::pcm_clipped;
#(
  parameter int BITS      = 10,
  parameter int DEPTH     = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  input  logic [31:0]          in_dout,
  input  logic [31:0]          volume,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [OUT_WIDTH-1:0] out_din,
  output logic [31:0]          sample_count,
  output logic [15:0]          sat_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]        outstanding;
  logic                 rd_d;
  logic                 s0_valid;
  logic signed [31:0]   s0;
  logic                 s1_valid;
  logic signed [63:0]   prod;
  logic signed [63:0]   pcm_full;
  logic                 clip;
  logic [OUT_WIDTH-1:0] pcm_sat;
  logic                 buf_full;
  logic                 buf_empty;
  logic [OUT_WIDTH-1:0] buf_head;

  // Flow control: an upstream pop is a strobe taken only while a credit is free
  // (credits cover every sample in flight or buffered), so the buffer never
  // overflows; a downstream push fires whenever the buffer holds data and
  // out_full is low, with out_din valid in that same cycle.
  assign in_rd_en  = !reset && !in_empty && (outstanding < DEPTH_C);
  assign out_wr_en = !reset && !buf_empty && !out_full;
  assign out_din   = buf_empty ? '0 : buf_head;

  // Floor toward -inf: one shift removes both the sample and the gain fractions.
  assign pcm_full = prod >>> (2 * BITS);
  assign clip     = pcm_clipped(pcm_full);
  assign pcm_sat  = OUT_WIDTH'(SATURATE_PCM(pcm_full));

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding  <= '0;
      rd_d         <= 1'b0;
      s0_valid     <= 1'b0;
      s0           <= '0;
      s1_valid     <= 1'b0;
      prod         <= '0;
      sample_count <= '0;
      sat_count    <= '0;
    end else begin
      case ({in_rd_en, out_wr_en})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      rd_d     <= in_rd_en;
      s0_valid <= rd_d;
      if (rd_d) s0 <= $signed(in_dout);
      s1_valid <= s0_valid;
      if (s0_valid) prod <= s0 * $signed(volume);
      if (out_wr_en) sample_count <= sample_count + 32'd1;
      if (s1_valid && clip && (sat_count != 16'hffff)) sat_count <= sat_count + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(s1_valid && buf_full && !out_wr_en));
  end

  pcm_hold_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_WIDTH)
  ) u_hold (
    .clock (clock),
    .reset (reset),
    .wr_en (s1_valid),
    .din   (pcm_sat),
    .rd_en (out_wr_en),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (buf_head)
  );

endmodule

// File: tb/tb_audio_dequant_out.sv
// Bench for audio_dequant_out: upstream FIFO model, scoreboard against an
// arithmetic reference (floor(x*vol/2^20), clamped to 16-bit), vector table and corner sequences.
module tb_audio_dequant_out;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] in_dout;
  logic [31:0] volume;
  logic        out_full;
  logic        out_wr_en;
  logic [15:0] out_din;
  logic [31:0] sample_count;
  logic [15:0] sat_count;

  always #5 clock = ~clock;

  audio_dequant_out dut (
    .clock        (clock),
    .reset        (reset),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .in_dout      (in_dout),
    .volume       (volume),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_din      (out_din),
    .sample_count (sample_count),
    .sat_count    (sat_count)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] vol;
    logic [15:0] exp_out;
    bit          exp_clip;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] src_q [$];
  logic [15:0] exp_q [$];
  int          rd_cyc_q [$];
  int          cycle;
  int          n_cmp;
  int          n_err;
  bit          check_lat;
  int          rd_total;
  int          wr_total;
  int          first_rd;
  int          last_rd;
  int          last_wr;
  logic [15:0] last_out;
  int unsigned m_samples;
  int          m_sat;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: exact product, floor division by 2^20, then clamp.
  function automatic logic [15:0] model(input logic [31:0] x, input logic [31:0] v, output bit clip);
    longint p;
    longint q;
    p = longint'($signed(x)) * longint'($signed(v));
    q = p / 1048576;
    if ((p < 0) && (q * 1048576 != p)) q = q - 1;
    clip = (q > 32767) || (q < -32768);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic push_src(input logic [31:0] x);
    src_q.push_back(x);
    in_empty = 1'b0;
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    rd_cyc_q.delete();
    m_samples = 0;
    m_sat     = 0;
  endtask

  // One clock: sample strobes at the falling edge, update the models, then
  // present next-cycle inputs just after the rising edge.
  task automatic step();
    logic [31:0] nxt;
    logic [15:0] e;
    bit          c;
    bit          rd;
    bit          wr;
    int          rc;
    nxt = in_dout;
    @(negedge clock);
    rd = in_rd_en;
    wr = out_wr_en;
    if (rd) begin
      if (src_q.size() == 0) begin
        check("rd_while_empty", in_empty, 0);
      end else begin
        nxt = src_q.pop_front();
        e = model(nxt, volume, c);
        exp_q.push_back(e);
        rd_cyc_q.push_back(cycle);
        if (c && m_sat < 65535) m_sat++;
      end
      rd_total++;
      if (first_rd < 0) first_rd = cycle;
      last_rd = cycle;
    end
    if (wr) begin
      wr_total++;
      last_wr  = cycle;
      last_out = out_din;
      m_samples++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: actual out_din %0d, required no write (cycle %0d)", $signed(out_din), cycle);
      end else begin
        e  = exp_q.pop_front();
        rc = rd_cyc_q.pop_front();
        check("out_din", $signed(out_din), $signed(e));
        if (check_lat) check("latency", cycle - rc, 4);
      end
    end
    @(posedge clock);
    #1;
    cycle++;
    in_dout  = nxt;
    in_empty = (src_q.size() == 0);
  endtask

  task automatic run_until_idle(input int max, input bit rand_full, input string name);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < max) begin
      if (rand_full) out_full = ($urandom_range(0, 3) == 0);
      step();
      n++;
    end
    if (rand_full) out_full = 1'b0;
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: actual %0d pending, required 0", name, src_q.size() + exp_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_sample_count"}, sample_count, m_samples);
    check({tag, "_sat_count"}, sat_count, m_sat);
  endtask

  initial begin
    int n;
    int clips;
    n_cmp = 0; n_err = 0; cycle = 0;
    check_lat = 1'b0; first_rd = -1; last_rd = 0; last_wr = 0;
    rd_total = 0; wr_total = 0; last_out = '0;
    clear_model();

    vecs[0] = '{32'h00002800, 32'd1024, 16'd10,   1'b0};
    vecs[1] = '{32'hffffffff, 32'd1024, 16'hffff, 1'b0};
    vecs[2] = '{32'h00000200, 32'd1024, 16'd0,    1'b0};
    vecs[3] = '{32'd40960000, 32'd1024, 16'h7fff, 1'b1};
    vecs[4] = '{32'hfd8f0000, 32'd1024, 16'h8000, 1'b1};
    vecs[5] = '{32'd20480000, 32'd2048, 16'h7fff, 1'b1};
    vecs[6] = '{32'hfffffe00, 32'd1024, 16'hffff, 1'b0};
    vecs[7] = '{32'h00000c00, 32'd512,  16'd1,    1'b0};

    // Reset: read strobe must stay low even with data available.
    reset = 1'b1; in_empty = 1'b0; out_full = 1'b0; volume = 32'd1024; in_dout = '0;
    repeat (3) begin
      @(negedge clock);
      check("rd_during_reset", in_rd_en, 0);
      @(posedge clock); #1; cycle++;
    end
    reset = 1'b0; in_empty = 1'b1;
    @(negedge clock);
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_out_din", out_din, 0);
    check_counters("rst");
    @(posedge clock); #1; cycle++;

    // Vector table, one isolated sample per row.
    check_lat = 1'b1;
    clips = 0;
    for (int i = 0; i < 8; i++) begin
      volume = vecs[i].vol;
      push_src(vecs[i].x);
      run_until_idle(20, 1'b0, "table");
      if (vecs[i].exp_clip) clips++;
      check($sformatf("table%0d_out", i), $signed(last_out), $signed(vecs[i].exp_out));
      check($sformatf("table%0d_sample_count", i), sample_count, i + 1);
      check($sformatf("table%0d_sat_count", i), sat_count, clips);
    end

    // Backpressure: credits stop the reads at DEPTH outstanding.
    check_lat = 1'b0;
    volume = 32'd1024;
    out_full = 1'b1;
    for (int i = 0; i < 20; i++) push_src($urandom_range(0, 32'h00ffffff) - 32'h00800000);
    rd_total = 0; wr_total = 0;
    repeat (15) step();
    check("bp_reads_while_full", rd_total, 8);
    check("bp_writes_while_full", wr_total, 0);
    check("bp_rd_en_throttled", in_rd_en, 0);
    out_full = 1'b0;
    run_until_idle(100, 1'b0, "backpressure");
    check("bp_total_writes", wr_total, 20);
    check_counters("bp");

    // Throughput: 100 back-to-back samples.
    check_lat = 1'b1;
    rd_total = 0; wr_total = 0; first_rd = -1;
    for (int i = 0; i < 100; i++) push_src($urandom());
    run_until_idle(300, 1'b0, "throughput");
    check("tp_reads", rd_total, 100);
    check("tp_read_span", last_rd - first_rd, 99);
    check("tp_last_write", last_wr - first_rd, 103);
    check_counters("tp");

    // Randomised gains, data and output backpressure.
    check_lat = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      volume = $urandom_range(0, 6144) - 2048;
      for (int i = 0; i < 60; i++) push_src($urandom_range(0, 32'h08000000) - 32'h04000000);
      run_until_idle(2000, 1'b1, "random");
      check_counters($sformatf("rand%0d", ph));
    end

    // Reset with six samples outstanding.
    volume = 32'd1024;
    out_full = 1'b1;
    for (int i = 0; i < 10; i++) push_src(32'h00001000 + i);
    rd_total = 0; n = 0;
    while (rd_total < 6 && n < 20) begin
      step();
      n++;
    end
    check("mid_reads_before_reset", rd_total, 6);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rd_during_reset", in_rd_en, 0);
    @(posedge clock); #1; cycle++;
    reset = 1'b0;
    clear_model();
    in_empty = 1'b1; out_full = 1'b0;
    @(negedge clock);
    check("mid_out_wr_en", out_wr_en, 0);
    check("mid_out_din", out_din, 0);
    check_counters("mid");
    @(posedge clock); #1; cycle++;
    check_lat = 1'b1;
    push_src(32'h00001c00);
    run_until_idle(20, 1'b0, "post_reset");
    check("post_reset_out", $signed(last_out), 7);
    check_counters("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
